// File: rtl/aos_param_fifo_if.sv
// -----------------------------------------------------------------------------
// aos_param_fifo_if
// Valid/ready stream bundle used on both sides of aos_param_fifo.
//   valid : source has a beat on data
//   ready : sink accepts the beat this cycle
//   data  : WIDTH-bit payload
// Modports:
//   master : drives valid/data, observes ready (the source of a stream)
//   slave  : observes valid/data, drives ready (the sink of a stream)
// -----------------------------------------------------------------------------
interface aos_param_fifo_if #(
   parameter int WIDTH = 64
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/aos_param_fifo.sv
// -----------------------------------------------------------------------------
// aos_param_fifo
// Parametrised valid/ready FIFO backing the per-path *_FIFO_Type/*_FIFO_Depth
// knobs (SoftReg AXI-Lite, AMI2AXI4, PCIS2ABD). Any depth >= 2, not only
// powers of two.
//   FIFO_TYPE 0 : registered, data enqueued at edge N is visible in cycle N+1
//   FIFO_TYPE 1 : bypass, an empty FIFO forwards enq data combinationally
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear of pointers and occupancy
//   enq (slave) : producer stream in
//   deq (master): consumer stream out (head entry)
//   count       : entries held in storage (a bypassed beat is never counted)
//   almost_full : count >= AF_THRESH
// -----------------------------------------------------------------------------
module aos_param_fifo #(
   parameter int WIDTH     = 64,
   parameter int DEPTH     = 4,
   parameter int FIFO_TYPE = 0,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   aos_param_fifo_if.slave       enq,
   aos_param_fifo_if.master      deq,
   output logic [CW-1:0]         count,
   output logic                  almost_full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);

   generate
      if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_params
         $error("aos_param_fifo: illegal DEPTH/AF_THRESH combination");
      end
   endgenerate

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg,  count_next;

   logic empty, full;
   logic enq_fire, deq_fire, bypass, do_write, do_read;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == DEPTH_C);

   // enq_ready depends only on registered occupancy, never on deq_ready.
   assign enq.ready   = ~full;
   assign count       = count_reg;
   assign almost_full = (count_reg >= AF_C);

   generate
      if (FIFO_TYPE == 1) begin : g_bypass
         assign deq.valid = ~empty | enq.valid;
         assign deq.data  = empty ? enq.data : mem[rd_ptr_reg];
      end else begin : g_registered
         assign deq.valid = ~empty;
         assign deq.data  = mem[rd_ptr_reg];
      end
   endgenerate

   assign enq_fire = enq.valid & enq.ready;
   assign deq_fire = deq.valid & deq.ready;

   // When empty in bypass mode a dequeue can only be the forwarded beat, so
   // the beat never touches storage and the pointers stay put.
   assign bypass   = (FIFO_TYPE == 1) & empty & enq_fire & deq_fire;
   assign do_write = enq_fire & ~bypass & ~flush;
   assign do_read  = deq_fire & ~bypass & ~flush;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         // Explicit wrap compare so non-power-of-two depths stay correct.
         if (do_write) begin
            wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
         end
         if (do_read) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
         end
         case ({do_write, do_read})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage carries no reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr_reg] <= enq.data;
      end
   end

endmodule

// File: tb/tb_aos_param_fifo.sv
// -----------------------------------------------------------------------------
// tb_aos_param_fifo
// Directed bench for aos_param_fifo. Four instances share clk/rst_n:
//   u0 : type 0, DEPTH 3   (fill / drain order, full flag)
//   u1 : type 0, DEPTH 5   (randomly stalled 20-beat stream, pointer wrap)
//   u2 : type 1, DEPTH 4   (bypass and buffered paths)
//   u3 : type 0, DEPTH 4, AF_THRESH 3 (almost_full, flush, async reset)
// -----------------------------------------------------------------------------
module tb_aos_param_fifo;

   logic clk = 1'b0;
   logic rst_n;
   logic flush0, flush1, flush2, flush3;
   logic [1:0] c0;
   logic [2:0] c1, c2, c3;
   logic af0, af1, af2, af3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aos_param_fifo_if #(.WIDTH(8)) e0 ();
   aos_param_fifo_if #(.WIDTH(8)) d0 ();
   aos_param_fifo_if #(.WIDTH(8)) e1 ();
   aos_param_fifo_if #(.WIDTH(8)) d1 ();
   aos_param_fifo_if #(.WIDTH(8)) e2 ();
   aos_param_fifo_if #(.WIDTH(8)) d2 ();
   aos_param_fifo_if #(.WIDTH(8)) e3 ();
   aos_param_fifo_if #(.WIDTH(8)) d3 ();

   aos_param_fifo #(.WIDTH(8), .DEPTH(3), .FIFO_TYPE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush0), .enq(e0), .deq(d0),
      .count(c0), .almost_full(af0));
   aos_param_fifo #(.WIDTH(8), .DEPTH(5), .FIFO_TYPE(0)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush1), .enq(e1), .deq(d1),
      .count(c1), .almost_full(af1));
   aos_param_fifo #(.WIDTH(8), .DEPTH(4), .FIFO_TYPE(1)) u2 (
      .clk(clk), .rst_n(rst_n), .flush(flush2), .enq(e2), .deq(d2),
      .count(c2), .almost_full(af2));
   aos_param_fifo #(.WIDTH(8), .DEPTH(4), .FIFO_TYPE(0), .AF_THRESH(3)) u3 (
      .clk(clk), .rst_n(rst_n), .flush(flush3), .enq(e3), .deq(d3),
      .count(c3), .almost_full(af3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   int sent, recv, wraps;
   logic enq_f, deq_f;
   logic [2:0] old_ptr;

   initial begin
      rst_n  = 1'b0;
      flush0 = 0; flush1 = 0; flush2 = 0; flush3 = 0;
      e0.valid = 0; e0.data = '0; d0.ready = 0;
      e1.valid = 0; e1.data = '0; d1.ready = 0;
      e2.valid = 0; e2.data = '0; d2.ready = 0;
      e3.valid = 0; e3.data = '0; d3.ready = 0;

      // ---------------- reset state ----------------
      #2;
      chk("rst_count",       c0,       0);
      chk("rst_deq_valid",   d0.valid, 0);
      chk("rst_almost_full", af3,      0);
      chk("rst_enq_ready",   e0.ready, 1);
      #11 rst_n = 1'b1;
      tick;

      // ---------------- u0: fill 3 then drain ----------------
      e0.valid = 1; e0.data = 8'h11;
      tick;
      chk("fill_cnt1", c0, 1);
      e0.data = 8'h22;
      tick;
      chk("fill_cnt2", c0, 2);
      e0.data = 8'h33;
      tick;
      chk("fill_cnt3", c0, 3);
      chk("full_enq_ready", e0.ready, 0);
      e0.valid = 0;
      d0.ready = 1;
      #1;
      chk("drain_valid", d0.valid, 1);
      chk("drain_d0", d0.data, 8'h11);
      $display("u0 deq %02h", d0.data);
      tick;
      chk("drain_d1", d0.data, 8'h22);
      $display("u0 deq %02h", d0.data);
      tick;
      chk("drain_d2", d0.data, 8'h33);
      $display("u0 deq %02h", d0.data);
      tick;
      chk("drain_cnt0", c0, 0);
      chk("drain_empty", d0.valid, 0);
      d0.ready = 0;

      // ---------------- u1: stalled 20-beat stream ----------------
      sent = 0; recv = 0; wraps = 0;
      for (int cyc = 0; cyc < 2000 && recv < 20; cyc++) begin
         e1.valid = (sent < 20) && ($urandom_range(0, 3) != 0);
         e1.data  = 8'(sent);
         d1.ready = ($urandom_range(0, 2) != 0);
         #1;
         enq_f = e1.valid & e1.ready;
         deq_f = d1.valid & d1.ready;
         if (deq_f) begin
            chk("stream_data", d1.data, recv);
            $display("u1 deq %02h count %0d", d1.data, c1);
         end
         old_ptr = u1.rd_ptr_reg;
         tick;
         if (enq_f) sent++;
         if (deq_f) recv++;
         if (old_ptr == 3'd4 && u1.rd_ptr_reg == 3'd0) wraps++;
         chk("stream_cnt_le5", {31'b0, (c1 <= 3'd5)}, 1);
      end
      e1.valid = 0; d1.ready = 0;
      chk("stream_done", recv, 20);
      chk("stream_wraps_ge3", {31'b0, (wraps >= 3)}, 1);

      // ---------------- u2: bypass when empty ----------------
      e2.valid = 1; e2.data = 8'hAB; d2.ready = 1;
      #1;
      chk("byp_valid", d2.valid, 1);
      chk("byp_data", d2.data, 8'hAB);
      chk("byp_cnt_same", c2, 0);
      $display("u2 bypass deq %02h", d2.data);
      tick;
      e2.valid = 0;
      #1;
      chk("byp_cnt_after", c2, 0);
      chk("byp_empty_after", d2.valid, 0);

      // ---------------- u2: buffered when consumer stalls ----------------
      d2.ready = 0; e2.valid = 1; e2.data = 8'hCD;
      tick;
      e2.valid = 0;
      chk("buf_cnt1", c2, 1);
      d2.ready = 1;
      #1;
      chk("buf_valid", d2.valid, 1);
      chk("buf_data", d2.data, 8'hCD);
      $display("u2 deq %02h", d2.data);
      tick;
      d2.ready = 0;
      chk("buf_cnt0", c2, 0);

      // ---------------- u3: almost_full and flush ----------------
      e3.valid = 1; e3.data = 8'h01;
      tick;
      e3.data = 8'h02;
      tick;
      chk("af_at2", af3, 0);
      e3.data = 8'h03;
      tick;
      e3.valid = 0;
      chk("af_at3", af3, 1);
      chk("af_cnt3", c3, 3);
      d3.ready = 1;
      #1;
      chk("af_pop_data", d3.data, 8'h01);
      tick;
      d3.ready = 0;
      chk("af_after_pop", af3, 0);
      chk("af_cnt2", c3, 2);
      flush3 = 1; e3.valid = 1; e3.data = 8'h44;
      #1;
      chk("flush_enq_ready", e3.ready, 1);
      tick;
      flush3 = 0; e3.valid = 0;
      #1;
      chk("flush_cnt", c3, 0);
      chk("flush_deq_valid", d3.valid, 0);
      chk("flush_enq_ready_after", e3.ready, 1);
      chk("flush_af", af3, 0);

      // ---------------- u3: asynchronous reset mid-operation ----------------
      tick;
      e3.valid = 1; e3.data = 8'h05;
      tick;
      e3.data = 8'h06;
      tick;
      e3.valid = 0;
      chk("pre_rst_cnt", c3, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_cnt", c3, 0);
      chk("async_rst_valid", d3.valid, 0);
      chk("async_rst_enq_ready", e3.ready, 1);
      #2 rst_n = 1'b1;
      tick;
      e3.valid = 1; e3.data = 8'h07;
      tick;
      e3.valid = 0;
      chk("post_rst_cnt", c3, 1);
      chk("post_rst_valid", d3.valid, 1);
      chk("post_rst_data", d3.data, 8'h07);
      $display("u3 head %02h after reset", d3.data);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aos_param_fifo.md
Name: aos_param_fifo

Overview:
- Parametrised valid/ready FIFO that realises the per-path *_FIFO_Type / *_FIFO_Depth configuration knobs used across AmorphOS F1 paths: AXI-Lite SoftReg, AMI2AXI4 and PCIS2ABD.
- Supports arbitrary width, any depth ≥ 2 (not only powers of two), two latency modes (registered and bypass), an occupancy count, an almost-full flag and a synchronous flush.
- One instance is used per buffered channel. Mode and depth are set from the configuration package.

Parameters:
- WIDTH, 64: data bits per entry.
- DEPTH, 4: number of storage entries; legal range 2..1024; need not be a power of two.
- FIFO_TYPE, 0: 0 = registered, 1-cycle latency; 1 = bypass, 0-cycle latency when empty.
- AF_THRESH, DEPTH-1: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- CW, $clog2(DEPTH+1): width of count (derived; not overridden).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous clear of all contents.
- enq_valid, input, 1: producer has data.
- enq_data, input, WIDTH: producer data.
- enq_ready, output, 1: FIFO can accept data.
- deq_valid, output, 1: head entry valid.
- deq_data, output, WIDTH: head entry.
- deq_ready, input, 1: consumer accepts head.
- count, output, CW: entries held, not including a bypassed beat.
- almost_full, output, 1: count >= AF_THRESH.

Behaviour:
- Transfer rules: enqueue fires when enq_valid & enq_ready; dequeue fires when deq_valid & deq_ready.
- Reset (rst_n low, asynchronous): rd_ptr = wr_ptr = 0; count = 0; deq_valid = 0; almost_full = 0; enq_ready = 1. Storage contents are don't-care. deq_data is don't-care while deq_valid = 0.
- Storage is a circular array of DEPTH entries. Each pointer increments on its fire and wraps from DEPTH-1 to 0 (explicit compare, no modulo-2^n assumption).
- enq_ready = (count != DEPTH). It is combinational from registered state only, with no dependence on deq_ready.
- count updates on the next edge:
  - +1 on enqueue alone;
  - -1 on dequeue alone;
  - unchanged when both fire or neither fires.
- almost_full is decoded combinationally from the count register.
- FIFO_TYPE 0:
  - deq_valid = (count != 0).
  - Data enqueued at edge N is visible on deq_valid/deq_data after edge N, i.e. in cycle N+1.
  - An empty FIFO never presents same-cycle data.
  - Simultaneous enqueue and dequeue with 0 < count < DEPTH is legal; count stays the same.
  - Simultaneous enqueue and dequeue at count == DEPTH is impossible, because enq_ready = 0.
- FIFO_TYPE 1:
  - deq_valid = (count != 0) | enq_valid.
  - deq_data = enq_data when count == 0, otherwise the head entry.
  - If count == 0 and both fire in the same cycle, the beat bypasses: it is not written, and pointers and count are unchanged.
  - If count == 0, enq fires and deq_ready = 0, the beat is written normally (count → 1).
- Flush, sampled at the clock edge:
  - Clears pointers and count to 0.
  - Flush has priority: any enqueue or dequeue in the same cycle is discarded, but producer and consumer still see their handshake as fired.
  - In type 1, a bypass beat in the flush cycle is still delivered, since it is combinational.
- Ordering: strict FIFO order, no reordering.
- Data: no data corruption for any DEPTH value, including non-powers of two.
- Illegal parameters: DEPTH < 2 or AF_THRESH outside 1..DEPTH stops elaboration via a generate-time check ($error).
- Reset asserted mid-operation: all state clears immediately and asynchronously. Outputs return to their reset values within the same cycle.

Test Plan:
- Type 0, DEPTH 3, WIDTH 8, deq_ready = 0: push 0x11, 0x22, 0x33.
  - After each push count reads 1, 2, 3; enq_ready is low after the 3rd push.
  - Set deq_ready = 1: data drains as 0x11, 0x22, 0x33 on consecutive cycles; count returns to 0.
- Type 0, DEPTH 5: stream 20 beats 0x00..0x13 with random stalls on both sides.
  - Output matches input order exactly.
  - Pointers wrap 4 → 0 at least 3 times.
  - count never exceeds 5.
- Type 1, empty, deq_ready = 1: enq 0xAB for one cycle.
  - deq_valid = 1 with deq_data = 0xAB in the same cycle.
  - count stays 0 throughout.
- Type 1 with deq_ready = 0: enq 0xCD, then raise deq_ready.
  - count goes to 1.
  - 0xCD is dequeued; count returns to 0.
- DEPTH 4, AF_THRESH 3: push 3 beats → almost_full = 1; pop 1 → almost_full = 0.
  - Then assert flush together with enq_valid: next cycle count = 0, deq_valid = 0 (type 0), enq_ready = 1.
- Fill 2 entries, then drop rst_n asynchronously between clock edges.
  - count = 0 and deq_valid = 0 immediately, before the next clk edge.
  - After reset releases, the first push appears correctly.
